// File: rtl/instr_pkg.sv
// Shared opcodes, field positions, FSM states and the built-in program for the fetch/execute stage.
// Pure definitions: no latency and no backpressure of its own.
package instr_pkg;

  localparam int INSTR_W = 8;
  localparam int OPC_LSB = 6;
  localparam int TGT_LSB = 4;
  localparam int IMM_LSB = 0;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam logic [INSTR_W-1:0] NOP_WORD = 8'h00;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // LDI 3; DEC; JMP->01; NOP
  localparam logic [INSTR_W-1:0] DEFAULT_PROG [4] = '{8'h43, 8'h80, 8'hD0, 8'h00};

  function automatic logic [1:0] opcode(input logic [INSTR_W-1:0] word);
    return word[OPC_LSB +: 2];
  endfunction

endpackage

// File: rtl/instr_fetch_exec_if.sv
// Bus between the 2-bit program counter / loader and the fetch/execute stage.
// Loader side uses valid/ready; everything else is a plain per-cycle level.
interface instr_fetch_exec_if;
  logic       pc0;
  logic       pc1;
  logic       start;
  logic       stop;
  logic       ld_valid;
  logic       ld_ready;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic       a0;
  logic       b0;
  logic       status;
  logic       running;

  modport master (
    output pc0, pc1, start, stop, ld_valid, ld_addr, ld_data,
    input  ld_ready, a0, b0, status, running
  );

  modport slave (
    input  pc0, pc1, start, stop, ld_valid, ld_addr, ld_data,
    output ld_ready, a0, b0, status, running
  );
endinterface

// File: rtl/prog_mem.sv
// 4x8 program store: synchronous write, combinational read feeding the IR register (PROG_LOAD_EN selects RAM vs ROM).
// Write visible to the read port on the following cycle; never stalls.
module prog_mem
  import instr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [1:0]         waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [1:0]         raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

`ifdef PROG_LOAD_EN
  // Contents deliberately survive reset so a loaded program can be rerun.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end
`else
  logic unused_wr_port;
  assign mem            = DEFAULT_PROG;
  assign unused_wr_port = ^{clk, we, waddr, wdata};
`endif

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_exec.sv
// Fetch/execute stage: IR <= mem[pc] (1 cycle), execute on the next edge; a0/b0 combinational from IR.
// Loader is accepted only in IDLE (ld_ready); PROG_LOAD_EN undefined gives a fixed ROM and ld_ready=0.
module instr_fetch_exec
  import instr_pkg::*;
#(
  parameter int ACC_W = 4,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_exec_if.slave bus
);

  localparam logic [ACC_W-1:0] ACC_ONE = 1;

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir, ir_nxt, mem_rdat;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic               status, status_nxt;
  logic               ld_fire;

  prog_mem #(.DEPTH(DEPTH)) u_prog_mem (
    .clk   (clk),
    .we    (ld_fire),
    .waddr (bus.ld_addr),
    .wdata (bus.ld_data),
    .raddr ({bus.pc1, bus.pc0}),
    .rdata (mem_rdat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ir     <= NOP_WORD;
      acc    <= '0;
      status <= 1'b1;
    end else begin
      state  <= state_nxt;
      ir     <= ir_nxt;
      acc    <= acc_nxt;
      status <= status_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    status_nxt = status;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_RUN;
      S_RUN:  if (bus.stop)  state_nxt = S_IDLE;
    endcase
    // Fetch on every edge that lands in RUN, including the start edge; NOP otherwise.
    ir_nxt = (state_nxt == S_RUN) ? mem_rdat : NOP_WORD;
    case (opcode(ir))
      OP_LDI: begin
        acc_nxt    = ir[IMM_LSB +: ACC_W];
        status_nxt = (acc_nxt == '0);
      end
      OP_DEC: begin
        acc_nxt    = acc - ACC_ONE;
        status_nxt = (acc_nxt == '0);
      end
      default: ;
    endcase
  end

`ifdef PROG_LOAD_EN
  assign bus.ld_ready = (state == S_IDLE);
`else
  assign bus.ld_ready = 1'b0;
`endif

  assign ld_fire     = bus.ld_valid & bus.ld_ready;
  assign bus.a0      = (opcode(ir) == OP_JMP) & ir[TGT_LSB];
  assign bus.b0      = (opcode(ir) == OP_JMP) & ir[TGT_LSB+1];
  assign bus.status  = status;
  assign bus.running = (state == S_RUN);

endmodule

// File: tb/tb_instr_fetch_exec.sv
// Bench for instr_fetch_exec: per-cycle vector table plus an IR scoreboard, then load/ROM corner sequences.
module tb_instr_fetch_exec;
  import instr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_exec_if bus();

  instr_fetch_exec #(.ACC_W(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef PROG_LOAD_EN
  localparam logic LDR = 1'b1;
`else
  localparam logic LDR = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] pc;
    logic       run;
    logic [3:0] acc;
    logic       status;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] prog [4];
  logic [7:0] exp_q [$];
  logic       m_run;
  logic [7:0] w;
  vec_t       vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(input logic r, input logic s, input logic p, input logic [1:0] pc,
                             input logic run, input logic [3:0] acc, input logic st);
    vec_t x;
    x.rst = r; x.start = s; x.stop = p; x.pc = pc;
    x.run = run; x.acc = acc; x.status = st;
    return x;
  endfunction

  task automatic set_pc(input logic [1:0] pc);
    bus.pc0 = pc[0];
    bus.pc1 = pc[1];
  endtask

  initial begin
    prog = '{8'h43, 8'h80, 8'hD0, 8'h00};
    //            rst start stop pc  | run acc    status
    vecs[0]  = v(0, 1, 0, 2'd0, 0, 4'h0, 1);
    vecs[1]  = v(0, 0, 0, 2'd1, 1, 4'h0, 1);
    vecs[2]  = v(0, 0, 0, 2'd1, 1, 4'h3, 0);
    vecs[3]  = v(0, 0, 0, 2'd1, 1, 4'h2, 0);
    vecs[4]  = v(0, 0, 0, 2'd2, 1, 4'h1, 0);
    vecs[5]  = v(0, 0, 0, 2'd1, 1, 4'h0, 1);
    vecs[6]  = v(0, 0, 0, 2'd3, 1, 4'h0, 1);
    vecs[7]  = v(0, 0, 0, 2'd0, 1, 4'hF, 0);
    vecs[8]  = v(1, 0, 0, 2'd0, 1, 4'hF, 0);
    vecs[9]  = v(0, 0, 0, 2'd0, 0, 4'h0, 1);
    vecs[10] = v(0, 1, 1, 2'd0, 0, 4'h0, 1);
    vecs[11] = v(0, 0, 0, 2'd2, 1, 4'h0, 1);
    vecs[12] = v(0, 1, 1, 2'd0, 1, 4'h3, 0);
    vecs[13] = v(0, 0, 0, 2'd0, 0, 4'h3, 0);
    vecs[14] = v(0, 0, 1, 2'd0, 0, 4'h3, 0);
    vecs[15] = v(0, 0, 0, 2'd0, 0, 4'h3, 0);

    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.ld_valid = 1'b0;
    bus.ld_addr = 2'd0; bus.ld_data = 8'h00;
    set_pc(2'd0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_status", bus.status, 1);
    check("reset_a0", bus.a0, 0);
    check("reset_b0", bus.b0, 0);
    check("reset_ld_ready", bus.ld_ready, LDR);
    check("reset_running", bus.running, 0);
    check("reset_acc", dut.acc, 0);
    check("reset_ir", dut.ir, 0);
    tick();

`ifdef PROG_LOAD_EN
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 2'(i);
      bus.ld_data  = prog[i];
      @(negedge clk);
      check("load_ld_ready", bus.ld_ready, 1);
      tick();
    end
`else
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 2'd0;
    bus.ld_data  = 8'hFF;
    @(negedge clk);
    check("rom_ld_ready", bus.ld_ready, 0);
    tick();
`endif
    bus.ld_valid = 1'b0;

    m_run = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rst       = vecs[i].rst;
      bus.start = vecs[i].start;
      bus.stop  = vecs[i].stop;
      set_pc(vecs[i].pc);
      @(negedge clk);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check($sformatf("v%0d_ir", i), dut.ir, w);
        check($sformatf("v%0d_a0", i), bus.a0, (w[7:6] == 2'b11) & w[4]);
        check($sformatf("v%0d_b0", i), bus.b0, (w[7:6] == 2'b11) & w[5]);
      end
      check($sformatf("v%0d_running", i), bus.running, vecs[i].run);
      check($sformatf("v%0d_acc", i), dut.acc, vecs[i].acc);
      check($sformatf("v%0d_status", i), bus.status, vecs[i].status);
      check($sformatf("v%0d_ld_ready", i), bus.ld_ready, LDR & ~vecs[i].run);
      if (vecs[i].rst) m_run = 1'b0;
      else if (m_run)  m_run = ~vecs[i].stop;
      else             m_run = vecs[i].start;
      exp_q.push_back(m_run ? prog[vecs[i].pc] : 8'h00);
      tick();
    end
    rst = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    @(negedge clk);
    w = exp_q.pop_front();
    check("tail_ir", dut.ir, w);
    tick();

`ifdef PROG_LOAD_EN
    // Write and start in the same IDLE cycle; the new word is fetched in the first RUN cycle.
    bus.ld_valid = 1'b1; bus.ld_addr = 2'd1; bus.ld_data = 8'h45;
    bus.start = 1'b1;
    set_pc(2'd0);
    tick();
    bus.ld_valid = 1'b0; bus.start = 1'b0;
    set_pc(2'd1);
    @(negedge clk);
    check("wrstart_ir0", dut.ir, 8'h43);
    check("wrstart_running", bus.running, 1);
    tick();
    set_pc(2'd0);
    @(negedge clk);
    check("wrstart_ir1", dut.ir, 8'h45);
    tick();
    @(negedge clk);
    check("wrstart_acc", dut.acc, 4'h5);
    check("wrstart_status", bus.status, 0);
`else
    // Load port ignored: ROM word 0 survives a write attempt and the default program runs.
    bus.ld_valid = 1'b1; bus.ld_addr = 2'd0; bus.ld_data = 8'hFF;
    bus.start = 1'b1;
    set_pc(2'd0);
    tick();
    bus.start = 1'b0;
    set_pc(2'd1);
    @(negedge clk);
    check("rom_ir0", dut.ir, 8'h43);
    check("rom_ld_ready_run", bus.ld_ready, 0);
    tick();
    bus.ld_valid = 1'b0;
    @(negedge clk);
    check("rom_ir1", dut.ir, 8'h80);
    check("rom_acc", dut.acc, 4'h3);
`endif
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    @(negedge clk);
    check("final_running", bus.running, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_exec.md
# instr_fetch_exec

Instruction fetch/execute stage paired with the 2-bit program counter that supports conditional jumps. It consumes the counter's `pc0`/`pc1` address, fetches an 8-bit instruction from a 4-entry program memory into an instruction register, executes it against a 4-bit accumulator, and returns the jump target (`a0`, `b0`) and `status` flag that the counter samples on the next cycle. It also owns program loading and start/stop control.

## Interface
Parameters:
- `ACC_W`, 4, accumulator width; the immediate field width equals `ACC_W`.
- `DEPTH`, 4, program memory entries; fixed by the 2-bit PC.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `pc0`, `pc1`  in  1 each  fetch address, LSB and MSB.
- `start`  in  1  single-cycle pulse: IDLE→RUN.
- `stop`  in  1  single-cycle pulse: RUN→IDLE.
- `ld_valid`  in  1  program write request.
- `ld_ready`  out  1  program write accepted when `ld_valid & ld_ready`.
- `ld_addr`  in  2  write address.
- `ld_data`  in  8  instruction word.
- `a0`, `b0`  out  1 each  jump target, LSB and MSB.
- `status`  out  1  accumulator-zero flag.
- `running`  out  1  high in RUN.

## Operation
- Instruction format: `[7:6]` opcode, `[5:4]` target (`b0`,`a0`), `[3:0]` imm.
- Opcodes:
  - 00 NOP: no effect.
  - 01 LDI: acc ← imm.
  - 10 DEC: acc ← acc−1, wrapping modulo 2^ACC_W (0→F).
  - 11 JMP: no accumulator effect; target is presented on `a0`/`b0`.
- `status` ← (new acc == 0) on LDI/DEC; otherwise held.
- FSM states:
  - IDLE: `ld_ready`=1; memory writable; IR forced to NOP.
  - RUN: `ld_ready`=0; IR ← mem[{pc1,pc0}] every cycle; the instruction in IR executes on the following edge.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→IDLE on `stop`.
  - `start` is ignored in RUN; `stop` is ignored in IDLE.
  - `start` and `stop` in the same cycle: the current state's exit condition wins.
- Write and `start` in the same IDLE cycle: the write is committed and the state enters RUN.
- Leaving RUN: the IR is cleared to NOP on the transition edge; acc and status are held.
- `a0`/`b0` = IR target field when the IR opcode is JMP, else 0.
- Reset values:
  - state IDLE; IR = NOP; acc = 0.
  - `status`=1, `a0`=`b0`=0, `running`=0, `ld_ready`=1.
  - Memory contents are unaffected by reset.

## Timing
- Fetch latency is 1 cycle: the PC presented in cycle n is in the IR in cycle n+1.
- Execute: acc/status update at the end of cycle n+1 and are visible in cycle n+2.
- `a0`/`b0` are combinational from the IR, valid in cycle n+1.
- `status` is registered.
- A write accepted in cycle n is readable by a fetch in cycle n+1.
- Reset asserted mid-RUN: all state takes the reset values at the next edge. An in-flight instruction is discarded without executing.

## Configuration
- `PROG_LOAD_EN` defined: load port functional as above.
- `PROG_LOAD_EN` undefined:
  - `ld_ready` tied 0 and `ld_*` inputs ignored.
  - Memory is a constant ROM initialised from the package default program: LDI 3; DEC; JMP→01; NOP.

## Structure
- Shared package `instr_pkg`:
  - opcode constants `OP_NOP`/`OP_LDI`/`OP_DEC`/`OP_JMP`;
  - field position constants;
  - FSM state typedef;
  - `DEFAULT_PROG` array.
- Sub-module `prog_mem` (4×8, one synchronous write port, one synchronous read into the IR). The ROM variant is selected inside `prog_mem` by `PROG_LOAD_EN`.

## Test plan
- Reset, then idle:
  - `status`=1, `a0`=`b0`=0, `ld_ready`=1, `running`=0.
- Load with pc held at 0:
  - Write 0x43 @0, 0x80 @1, 0xD0 @2, 0x00 @3; pulse `start`.
  - Next cycle: IR=0x43.
  - Two cycles after `start`: acc=3, `status`=0.
- Stepping:
  - pc=1: DEC three times, acc 3→2→1→0; `status` rises exactly two cycles after the third DEC is fetched.
  - pc=2: `a0`=1, `b0`=0 in the fetch+1 cycle.
- Wrap-around:
  - LDI 0 then DEC → acc=0xF, `status`=0.
- Simultaneous events:
  - `start`+`stop` in IDLE → enters RUN.
  - `start`+`stop` in RUN → enters IDLE; IR=NOP and `a0`/`b0`=0 next cycle.
  - `ld_valid`+`start` in IDLE → write lands and is fetchable on the first RUN cycle.
- `rst` pulsed in the cycle an LDI 7 sits in the IR:
  - acc=0, `status`=1, state IDLE, memory retained.
  - Without `PROG_LOAD_EN`: `ld_ready` stays 0 and the default program executes.
